// File: rtl/bit_iter_pkg.sv
// Shared types and default constants for the bounded bit-iteration engine.
package bit_iter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } bit_iter_state_t;

  localparam int BIT_ITER_WIDTH = 16;
  localparam int BIT_ITER_START = 1;
  localparam int BIT_ITER_MAX   = 10;

endpackage

// File: rtl/bit_iter_seq.sv
// Bit-iteration engine: walks one bit position per cycle, writing result[i] = ~din[i-1],
// bounded by MAX_ITER steps or the top bit, then presents the word on a valid/ready port.
module bit_iter_seq
  import bit_iter_pkg::*;
#(
  parameter int WIDTH     = BIT_ITER_WIDTH,
  parameter int START_IDX = BIT_ITER_START,
  parameter int MAX_ITER  = BIT_ITER_MAX
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(WIDTH+1)-1:0] out_count,
  output logic                       busy
);

  localparam int IDX_W = $clog2(WIDTH);
  localparam int CNT_W = $clog2(WIDTH+1);

  if (START_IDX < 1 || START_IDX > WIDTH - 1) begin : g_bad_start
    $error("bit_iter_seq: START_IDX must lie in 1..WIDTH-1");
  end
  if (MAX_ITER < 1) begin : g_bad_max
    $error("bit_iter_seq: MAX_ITER must be >= 1");
  end

  bit_iter_state_t    state_reg, state_next;
  logic [WIDTH-1:0]   din_reg;
  logic [WIDTH-1:0]   res_reg;
  logic [IDX_W-1:0]   idx_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic               out_valid_reg;
  logic [WIDTH-1:0]   out_data_reg;
  logic [CNT_W-1:0]   out_count_reg;
  logic               in_fire;
  logic               last_step;

  assign in_fire   = in_valid && in_ready;
  // Top-bit termination fires before idx could overflow its register.
  assign last_step = (int'(cnt_reg) + 1 == MAX_ITER) || (int'(idx_reg) == WIDTH - 1);

  always_comb begin
    state_next = state_reg;
    in_ready   = (state_reg == IDLE) && !rst;
    case (state_reg)
      IDLE: if (in_fire) state_next = RUN;
      RUN:  if (last_step) state_next = DONE;
      DONE: if (out_valid_reg && out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      din_reg       <= '0;
      res_reg       <= '0;
      idx_reg       <= '0;
      cnt_reg       <= '0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_count_reg <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (in_fire) begin
            din_reg <= in_data;
            res_reg <= '0;
            idx_reg <= IDX_W'(START_IDX);
            cnt_reg <= '0;
          end
        end
        RUN: begin
          res_reg[idx_reg] <= ~din_reg[idx_reg - 1'b1];
          cnt_reg          <= cnt_reg + 1'b1;
          if (!last_step) idx_reg <= idx_reg + 1'b1;
        end
        DONE: begin
          // Result registers load once on DONE entry and stay frozen while stalled.
          if (!out_valid_reg) begin
            out_valid_reg <= 1'b1;
            out_data_reg  <= res_reg;
            out_count_reg <= cnt_reg;
          end else if (out_ready) begin
            out_valid_reg <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_count = out_count_reg;
  assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_bit_iter_seq.sv
// Randomized self-checking bench for bit_iter_seq with a step-rule reference model;
// two instances cover step-limited and top-bit-limited termination.
module tb_bit_iter_seq;
  import bit_iter_pkg::*;

  localparam int W = 16;
  localparam int CW = $clog2(W+1);

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid  [2];
  logic          in_ready  [2];
  logic [W-1:0]  in_data   [2];
  logic          out_valid [2];
  logic          out_ready [2];
  logic [W-1:0]  out_data  [2];
  logic [CW-1:0] out_count [2];
  logic          busy      [2];

  int n_checks = 0;
  int n_fail   = 0;
  int max_iter_of [2];
  logic [W-1:0] last_data;
  int last_cnt;

  always #5 clk = ~clk;

  bit_iter_seq #(.WIDTH(W), .START_IDX(1), .MAX_ITER(10)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
    .out_count(out_count[0]), .busy(busy[0])
  );

  bit_iter_seq #(.WIDTH(W), .START_IDX(1), .MAX_ITER(20)) dut20 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
    .out_count(out_count[1]), .busy(busy[1])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: k = min(MAX_ITER, W-START) steps, each setting bit i to din[i-1]+1 mod 2.
  function automatic int model_steps(input int max_iter);
    int span;
    span = W - 1;
    return (max_iter < span) ? max_iter : span;
  endfunction

  function automatic logic [W-1:0] model_data(input logic [W-1:0] din, input int max_iter);
    logic [W-1:0] r;
    int k;
    r = '0;
    k = model_steps(max_iter);
    for (int step = 0; step < k; step++) begin
      int pos;
      pos = 1 + step;
      r[pos] = (din[pos-1] + 1'b1) % 2;
    end
    return r;
  endfunction

  task automatic run_word(input int s, input logic [W-1:0] din, input int stall,
                          input logic [W-1:0] junk);
    logic [W-1:0] exp_d;
    int exp_k;
    int lat;
    int wait_n;
    exp_d = model_data(din, max_iter_of[s]);
    exp_k = model_steps(max_iter_of[s]);
    @(negedge clk);
    in_valid[s] = 1'b1;
    in_data[s]  = din;
    wait_n = 0;
    while (!in_ready[s] && wait_n < 50) begin
      @(negedge clk);
      wait_n++;
    end
    if (wait_n >= 50) check("in_ready_timeout", 32'(wait_n), 32'd0);
    @(negedge clk);
    in_valid[s] = 1'b0;
    check("busy_after_accept", 32'(busy[s]), 32'd1);
    lat = 0;
    while (!out_valid[s] && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check("latency", 32'(lat), 32'(exp_k + 1));
    for (int j = 0; j < stall; j++) begin
      in_valid[s] = 1'b1;
      in_data[s]  = junk;
      check("stall_valid", 32'(out_valid[s]), 32'd1);
      check("stall_data", 32'(out_data[s]), 32'(exp_d));
      check("stall_count", 32'(out_count[s]), 32'(exp_k));
      check("stall_in_ready", 32'(in_ready[s]), 32'd0);
      @(negedge clk);
    end
    in_valid[s]  = 1'b0;
    out_ready[s] = 1'b1;
    check("out_data", 32'(out_data[s]), 32'(exp_d));
    check("out_count", 32'(out_count[s]), 32'(exp_k));
    last_data = out_data[s];
    last_cnt  = int'(out_count[s]);
    $display("word dut=%0d din=0x%04h out=0x%04h count=%0d latency=%0d stall=%0d",
             s, din, out_data[s], out_count[s], lat, stall);
    @(negedge clk);
    out_ready[s] = 1'b0;
    check("valid_drop", 32'(out_valid[s]), 32'd0);
    check("idle_busy", 32'(busy[s]), 32'd0);
    check("idle_in_ready", 32'(in_ready[s]), 32'd1);
  endtask

  initial begin
    int seen;
    max_iter_of[0] = 10;
    max_iter_of[1] = 20;
    for (int i = 0; i < 2; i++) begin
      in_valid[i]  = 1'b0;
      in_data[i]   = '0;
      out_ready[i] = 1'b0;
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_out_valid", 32'(out_valid[0]), 32'd0);
    check("rst_out_data", 32'(out_data[0]), 32'd0);
    check("rst_out_count", 32'(out_count[0]), 32'd0);
    check("rst_busy", 32'(busy[0]), 32'd0);
    check("rst_in_ready", 32'(in_ready[0]), 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 32'(in_ready[0]), 32'd1);

    run_word(0, 16'h0000, 0, 16'h0000);
    check("dir_zero_data", 32'(last_data), 32'h07FE);
    check("dir_zero_count", 32'(last_cnt), 32'd10);
    run_word(0, 16'hFFFF, 1, 16'h0000);
    check("dir_ones_data", 32'(last_data), 32'h0000);
    run_word(0, 16'h00FF, 0, 16'h0000);
    check("dir_00ff_data", 32'(last_data), 32'h0600);
    run_word(1, 16'h0000, 0, 16'h0000);
    check("dir_top_data", 32'(last_data), 32'hFFFE);
    check("dir_top_count", 32'(last_cnt), 32'd15);
    run_word(0, 16'h1234, 5, 16'hFFFF);
    run_word(0, 16'hA5C3, 0, 16'h0000);

    // Reset in the middle of RUN must drop the word entirely.
    @(negedge clk);
    in_valid[0] = 1'b1;
    in_data[0]  = 16'h0000;
    @(negedge clk);
    in_valid[0] = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_in_ready_low", 32'(in_ready[0]), 32'd0);
    rst = 1'b0;
    #1;
    check("midrst_in_ready", 32'(in_ready[0]), 32'd1);
    check("midrst_busy", 32'(busy[0]), 32'd0);
    seen = 0;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      if (out_valid[0]) seen++;
    end
    check("midrst_no_valid", 32'(seen), 32'd0);
    run_word(0, 16'h5A5A, 0, 16'h0000);

    for (int t = 0; t < 40; t++) begin
      int s;
      s = (t % 4 == 3) ? 1 : 0;
      run_word(s, W'($urandom), $urandom_range(0, 4), W'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
